dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the MIPS core's load/store port and a debug/loader port (bench preload, display readback, future DMA).
- Sits between the mips core, the debug requester and dmem, inside the top level.
- Fixed priority to the core, with a starvation guard for the debug port.
- Stalls the pipeline when the core loses arbitration and routes the registered read data back to the winner.

---
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the core load/store port and a debug/loader port.
// Optional access statistics are compiled in with `define DMEM_ARB_STATS_EN; otherwise stat_* read 0.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 32
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    output logic          c_stall,
    output logic          c_rvalid,
    output logic [31:0]   c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata,
    output logic [31:0]   stat_core_acc,
    output logic [31:0]   stat_dbg_acc,
    output logic [31:0]   stat_stall,
    output logic [1:0]    o_dbg_owner,
    output logic [3:0]    o_dbg_wait_cnt
);

    // Handshake: a requester holds req and payload stable while it loses; the core is
    // accepted in any cycle with c_req && !c_stall, debug in any cycle with d_gnt.
    // Read data returns exactly one cycle after acceptance with a one-cycle rvalid.

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    owner_t     r_owner;
    owner_t     w_owner_nxt;
    logic       w_dbg_win;
    logic       w_core_win;
    logic [3:0] r_wait_cnt;
    logic       r_force_dbg;

    always_comb begin
        w_dbg_win  = d_req && (!c_req || r_force_dbg);
        w_core_win = c_req && !w_dbg_win;
        m_we       = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        if (w_dbg_win) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (w_core_win) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end
        c_stall = c_req && w_dbg_win;
        d_gnt   = w_dbg_win;
    end

    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_dbg_win && !d_we) begin
            w_owner_nxt = OWN_DBG;
        end else if (w_core_win && !c_we) begin
            w_owner_nxt = OWN_CORE;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    always_comb begin
        c_rvalid = (r_owner == OWN_CORE);
        d_rvalid = (r_owner == OWN_DBG);
        c_rdata  = c_rvalid ? m_rdata : 32'd0;
        d_rdata  = d_rvalid ? m_rdata : 32'd0;
    end

    // force_dbg looks at the counter value of the previous cycle, so the debug port
    // wins once the counter has sat at MAX_WAIT for a full cycle.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_wait_cnt  <= 4'd0;
            r_force_dbg <= 1'b0;
        end else begin
            r_force_dbg <= (r_wait_cnt == LP_MAX_WAIT);
            if (d_req && !w_dbg_win) begin
                if (r_wait_cnt != LP_MAX_WAIT) begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
            end else begin
                r_wait_cnt <= 4'd0;
            end
        end
    end

    assign o_dbg_owner    = r_owner;
    assign o_dbg_wait_cnt = r_wait_cnt;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] r_stat_core_acc;
    logic [31:0] r_stat_dbg_acc;
    logic [31:0] r_stat_stall;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_stat_core_acc <= 32'd0;
            r_stat_dbg_acc  <= 32'd0;
            r_stat_stall    <= 32'd0;
        end else begin
            if (w_core_win && (r_stat_core_acc != 32'hFFFF_FFFF)) begin
                r_stat_core_acc <= r_stat_core_acc + 32'd1;
            end
            if (w_dbg_win && (r_stat_dbg_acc != 32'hFFFF_FFFF)) begin
                r_stat_dbg_acc <= r_stat_dbg_acc + 32'd1;
            end
            if (c_stall && (r_stat_stall != 32'hFFFF_FFFF)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_core_acc = r_stat_core_acc;
    assign stat_dbg_acc  = r_stat_dbg_acc;
    assign stat_stall    = r_stat_stall;
`else
    assign stat_core_acc = 32'd0;
    assign stat_dbg_acc  = 32'd0;
    assign stat_stall    = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then randomized traffic,
// all checked against a behavioural arbitration/memory model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int AW = 32;

  // clock / reset
  logic CLK = 1'b0;
  logic Reset = 1'b0;
  always #5 CLK = ~CLK;

  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [31:0]   c_wdata = '0;
  logic          c_stall, c_rvalid;
  logic [31:0]   c_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [31:0]   d_rdata;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;
  logic [31:0]   stat_core_acc, stat_dbg_acc, stat_stall;
  logic [1:0]    o_dbg_owner;
  logic [3:0]    o_dbg_wait_cnt;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW)) dut (
    .CLK(CLK), .Reset(Reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .stat_core_acc(stat_core_acc), .stat_dbg_acc(stat_dbg_acc), .stat_stall(stat_stall),
    .o_dbg_owner(o_dbg_owner), .o_dbg_wait_cnt(o_dbg_wait_cnt)
  );

  // single-port memory: registered read, write at the clock edge
  logic [31:0] mem [0:15];
  always @(posedge CLK) begin
    if (m_we) mem[m_addr[5:2]] <= m_wdata;
    m_rdata <= mem[m_addr[5:2]];
  end

  // reference model state
  logic [31:0] ref_mem [0:15];
  int          mdl_wait = 0;
  bit          mdl_force = 1'b0;
  bit          mdl_pend_c = 1'b0, mdl_pend_d = 1'b0;
  logic [31:0] mdl_pend_data = '0;
  int unsigned mdl_st_core = 0, mdl_st_dbg = 0, mdl_st_stall = 0;
  bit          mdl_c_lost = 1'b0, mdl_d_lost = 1'b0;

  // scoreboard counters and captured observations
  int checks = 0;
  int passes = 0;
  logic        obs_c_rvalid, obs_d_rvalid, obs_d_gnt, obs_c_stall;
  logic [31:0] obs_c_rdata, obs_d_rdata;
  logic [3:0]  obs_wait;
  logic [31:0] obs_st_core, obs_st_dbg, obs_st_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_model();
    mdl_wait = 0;
    mdl_force = 1'b0;
    mdl_pend_c = 1'b0;
    mdl_pend_d = 1'b0;
    mdl_pend_data = '0;
    mdl_st_core = 0;
    mdl_st_dbg = 0;
    mdl_st_stall = 0;
  endtask

  // one clock cycle: check everything mid-cycle, then advance the model at the edge
  task automatic cycle();
    bit dwin, cwin, new_force;
    @(negedge CLK);
    dwin = d_req && (!c_req || mdl_force);
    cwin = c_req && !dwin;
    obs_c_rvalid = c_rvalid; obs_c_rdata = c_rdata;
    obs_d_rvalid = d_rvalid; obs_d_rdata = d_rdata;
    obs_d_gnt = d_gnt; obs_c_stall = c_stall; obs_wait = o_dbg_wait_cnt;
    obs_st_core = stat_core_acc; obs_st_dbg = stat_dbg_acc; obs_st_stall = stat_stall;
    check("c_stall", c_stall, c_req && dwin);
    check("d_gnt", d_gnt, dwin);
    check("m_we", m_we, dwin ? d_we : (cwin ? c_we : 1'b0));
    check("m_addr", m_addr, dwin ? d_addr : (cwin ? c_addr : '0));
    check("m_wdata", m_wdata, dwin ? d_wdata : (cwin ? c_wdata : '0));
    check("c_rvalid", c_rvalid, mdl_pend_c);
    check("c_rdata", c_rdata, mdl_pend_c ? mdl_pend_data : 32'd0);
    check("d_rvalid", d_rvalid, mdl_pend_d);
    check("d_rdata", d_rdata, mdl_pend_d ? mdl_pend_data : 32'd0);
    check("wait_cnt", o_dbg_wait_cnt, mdl_wait);
`ifdef DMEM_ARB_STATS_EN
    check("stat_core_acc", stat_core_acc, mdl_st_core);
    check("stat_dbg_acc", stat_dbg_acc, mdl_st_dbg);
    check("stat_stall", stat_stall, mdl_st_stall);
`else
    check("stat_tied", stat_core_acc | stat_dbg_acc | stat_stall, 32'd0);
`endif
    mdl_c_lost = c_req && dwin;
    mdl_d_lost = d_req && !dwin;
    @(posedge CLK);
    if (Reset) begin
      new_force = (mdl_wait == MAX_WAIT);
      if (d_req && !dwin) mdl_wait = (mdl_wait < MAX_WAIT) ? mdl_wait + 1 : MAX_WAIT;
      else mdl_wait = 0;
      mdl_force = new_force;
      mdl_pend_c = cwin && !c_we;
      mdl_pend_d = dwin && !d_we;
      mdl_pend_data = '0;
      if (dwin) begin
        if (d_we) ref_mem[d_addr[5:2]] = d_wdata;
        else mdl_pend_data = ref_mem[d_addr[5:2]];
      end else if (cwin) begin
        if (c_we) ref_mem[c_addr[5:2]] = c_wdata;
        else mdl_pend_data = ref_mem[c_addr[5:2]];
      end
      if (cwin) mdl_st_core++;
      if (dwin) mdl_st_dbg++;
      if (c_req && dwin) mdl_st_stall++;
    end
    #1;
  endtask

  // driver tasks
  task automatic set_core(input logic req, input logic we, input logic [AW-1:0] a, input logic [31:0] wd);
    c_req = req; c_we = we; c_addr = a; c_wdata = wd;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [AW-1:0] a, input logic [31:0] wd);
    d_req = req; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  logic [9:0]  gnt_mask, stall_mask;
  logic [31:0] snap_core, snap_dbg, snap_stall;

  initial begin
    clear_model();
    // reset state
    cycle();
    cycle();
    check("rst_c_rvalid", obs_c_rvalid, 1'b0);
    check("rst_wait", obs_wait, 4'd0);
    Reset = 1'b1;
    cycle();

    // preload all words through the debug port; 0x10 holds 0xDEADBEEF
    for (int i = 0; i < 16; i++) begin
      set_dbg(1'b1, 1'b1, 32'(i * 4), (i == 4) ? 32'hDEAD_BEEF : $urandom);
      cycle();
      check("preload_gnt", obs_d_gnt, 1'b1);
    end
    set_dbg(1'b0, 1'b0, '0, '0);

    // core-only read of 0x10
    set_core(1'b1, 1'b0, 32'h10, '0);
    cycle();
    check("core_only_stall", obs_c_stall, 1'b0);
    set_core(1'b0, 1'b0, '0, '0);
    cycle();
    check("core_only_rvalid", obs_c_rvalid, 1'b1);
    check("core_only_rdata", obs_c_rdata, 32'hDEAD_BEEF);
    check("core_only_d_rvalid", obs_d_rvalid, 1'b0);

    // ten cycles of contention
    set_core(1'b1, 1'b0, 32'h0, '0);
    set_dbg(1'b1, 1'b0, 32'h4, '0);
    snap_core = '0; snap_dbg = '0; snap_stall = '0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      gnt_mask[i] = obs_d_gnt;
      stall_mask[i] = obs_c_stall;
      if (i == 0) begin
        snap_core = obs_st_core; snap_dbg = obs_st_dbg; snap_stall = obs_st_stall;
      end
    end
    set_core(1'b0, 1'b0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0);
    cycle();
    check("contention_gnt_mask", gnt_mask, 10'b00_0110_0000);
    check("contention_stall_mask", stall_mask, 10'b00_0110_0000);
`ifdef DMEM_ARB_STATS_EN
    check("contention_stat_core", obs_st_core - snap_core, 32'd8);
    check("contention_stat_dbg", obs_st_dbg - snap_dbg, 32'd2);
    check("contention_stat_stall", obs_st_stall - snap_stall, 32'd2);
`endif
    cycle();

    // debug write then core read of the same word
    set_dbg(1'b1, 1'b1, 32'h20, 32'h1234_5678);
    cycle();
    set_dbg(1'b0, 1'b0, '0, '0);
    set_core(1'b1, 1'b0, 32'h20, '0);
    cycle();
    check("wr_no_rvalid", obs_d_rvalid | obs_c_rvalid, 1'b0);
    set_core(1'b0, 1'b0, '0, '0);
    cycle();
    check("wr_rd_rvalid", obs_c_rvalid, 1'b1);
    check("wr_rd_rdata", obs_c_rdata, 32'h1234_5678);

    // alternating owners, back to back
    set_core(1'b1, 1'b0, 32'h0, '0);
    cycle();
    set_core(1'b0, 1'b0, '0, '0);
    set_dbg(1'b1, 1'b0, 32'h4, '0);
    cycle();
    check("alt1_c_rvalid", obs_c_rvalid, 1'b1);
    check("alt1_d_rvalid", obs_d_rvalid, 1'b0);
    set_dbg(1'b0, 1'b0, '0, '0);
    set_core(1'b1, 1'b0, 32'h8, '0);
    cycle();
    check("alt2_d_rvalid", obs_d_rvalid, 1'b1);
    check("alt2_c_rvalid", obs_c_rvalid, 1'b0);
    set_core(1'b0, 1'b0, '0, '0);
    cycle();
    check("alt3_c_rvalid", obs_c_rvalid, 1'b1);
    check("alt3_d_rvalid", obs_d_rvalid, 1'b0);

    // build up the wait counter, grant a core read, then reset in the return cycle
    set_core(1'b1, 1'b1, 32'h3C, 32'hA5A5_0001);
    set_dbg(1'b1, 1'b0, 32'h8, '0);
    for (int i = 0; i < 3; i++) cycle();
    set_core(1'b1, 1'b0, 32'h10, '0);
    cycle();
    Reset = 1'b0;
    clear_model();
    set_core(1'b0, 1'b0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0);
    cycle();
    check("rst_mid_c_rvalid", obs_c_rvalid, 1'b0);
    check("rst_mid_wait", obs_wait, 4'd0);
    cycle();
    Reset = 1'b1;
    cycle();
    check("rst_rel_c_rvalid", obs_c_rvalid, 1'b0);
    set_dbg(1'b1, 1'b0, 32'h10, '0);
    cycle();
    check("rst_first_dbg_gnt", obs_d_gnt, 1'b1);
    set_dbg(1'b0, 1'b0, '0, '0);
    cycle();

    // randomized traffic; a stalled core holds, debug may hold or drop
    for (int i = 0; i < 400; i++) begin
      if (!(c_req && mdl_c_lost)) begin
        set_core($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom);
      end
      if (d_req && mdl_d_lost) begin
        if ($urandom_range(0, 7) == 0) d_req = 1'b0;
      end else begin
        set_dbg($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, $urandom);
      end
      cycle();
    end
    set_core(1'b0, 1'b0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0);
    cycle();
    cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
